// File: rtl/riscv_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader state encoding and the image framing constants.
package riscv_boot_pkg;

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } boot_state_t;

  // Image header is a little-endian 16-bit word count
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // One bit wider than the header count so a full memory (2^ADDR_WIDTH words)
  // can be counted without wrapping
  localparam int COUNT_WIDTH = 8 * HDR_BYTES + 1;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot-time loader: receives a byte stream, assembles little-endian words and
// writes them into the instruction memory while holding the core in reset.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_boot_loader
  import riscv_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  boot_req,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  done,
  output logic                  err
);

  localparam logic [COUNT_WIDTH-1:0] MAX_WORDS = COUNT_WIDTH'(1) << ADDR_WIDTH;

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam boot_state_t ST_END = ST_CHK;
`else
  localparam boot_state_t ST_END = ST_DONE;
`endif

  boot_state_t            state_q, state_d;
  logic [7:0]             n_lo_q;
  logic [COUNT_WIDTH-1:0] n_words_q;
  logic [COUNT_WIDTH-1:0] word_cnt_q;
  logic [1:0]             byte_idx_q;
  logic [23:0]            word_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  logic                   accept;
  logic [COUNT_WIDTH-1:0] hdr_n;
  logic                   last_byte;
  logic                   last_word;

  assign accept    = in_valid && in_ready;
  assign hdr_n     = {1'b0, in_data, n_lo_q};
  assign last_byte = (byte_idx_q == 2'(BYTES_PER_WORD - 1));
  assign last_word = ((word_cnt_q + COUNT_WIDTH'(1)) == n_words_q);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_HDR0;
    else      state_q <= state_d;
  end

  // Next-state logic: header parse, word counting, checksum verdict, restart
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR0: if (accept) state_d = ST_HDR1;
      ST_HDR1: begin
        if (accept) begin
          if (hdr_n == '0)           state_d = ST_END;
          else if (hdr_n > MAX_WORDS) state_d = ST_ERR;
          else                        state_d = ST_DATA;
        end
      end
      ST_DATA: if (accept && last_byte && last_word) state_d = ST_END;
      ST_CHK: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (accept) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
`else
        state_d = ST_ERR;
`endif
      end
      ST_DONE, ST_ERR: if (boot_req) state_d = ST_HDR0;
      default: state_d = ST_ERR;
    endcase
  end

  // Datapath and registered outputs; status follows state one cycle late so
  // the core is released only after the final write strobe has completed
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      n_lo_q     <= '0;
      n_words_q  <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state_q)
        ST_HDR0: if (accept) n_lo_q <= in_data;
        ST_HDR1: begin
          if (accept) begin
            n_words_q  <= hdr_n;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (accept) begin
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= csum_q ^ in_data;
`endif
            case (byte_idx_q)
              2'd0: word_q[7:0]   <= in_data;
              2'd1: word_q[15:8]  <= in_data;
              2'd2: word_q[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt_q[ADDR_WIDTH-1:0];
                imem_wdata <= {in_data, word_q};
                word_cnt_q <= word_cnt_q + COUNT_WIDTH'(1);
              end
            endcase
          end
        end
        ST_DONE, ST_ERR: begin
          if (boot_req) begin
            n_words_q  <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        default: ;
      endcase
      in_ready   <= (state_d inside {ST_HDR0, ST_HDR1, ST_DATA, ST_CHK});
      core_rst_n <= (state_q == ST_DONE) && !boot_req;
      done       <= (state_q == ST_DONE) && !boot_req;
      err        <= (state_q == ST_ERR) && !boot_req;
    end
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time loader for the single-cycle RV32I core. It receives a byte stream over a valid/ready port, assembles little-endian 32-bit words, and writes them into the instruction ROM write port. The core is held in reset until the image is complete. It replaces simulation-only memory preloading, so the same program image can be delivered by a UART or debug bridge in hardware.

## Interface
- `ADDR_WIDTH`, 8: instruction memory word-address width; capacity is 2^ADDR_WIDTH words.
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `boot_req` in 1: single-cycle pulse; restarts loading from DONE or ERR.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out ADDR_WIDTH: word address.
- `imem_wdata` out 32: word to write.
- `core_rst_n` out 1: active-low reset to the RISC core.
- `done` out 1: image loaded, core running.
- `err` out 1: load failed.

## Operation
- Image format:
  - 2-byte word count N, little-endian.
  - Then 4·N bytes, each word little-endian, addresses 0..N-1.
  - With `IMEM_BOOT_CHECKSUM_EN`, one trailing checksum byte.
- A byte transfers when `in_valid && in_ready`.
- FSM states: HDR0, HDR1, DATA, CHK, DONE, ERR. Reset state is HDR0.
- HDR0: accept the byte into N[7:0]; go to HDR1.
- HDR1: accept the byte into N[15:8]. Then:
  - N == 0 → DONE (or CHK when the checksum is enabled).
  - N > 2^ADDR_WIDTH → ERR.
  - Otherwise → DATA with word counter = 0.
- DATA:
  - A 2-bit byte index places each byte at bits [8·idx+7:8·idx] of the word register.
  - On the 4th byte, the word is written to the current counter address and the counter increments.
  - After word N-1 is written → DONE (or CHK).
- CHK: accept one byte. It must equal the XOR of all 4·N data bytes; match → DONE, else → ERR.
- DONE: `core_rst_n=1`, `done=1`, `in_ready=0`.
- ERR: `err=1`, `core_rst_n=0`, `in_ready=0`.
- `boot_req` in DONE or ERR:
  - Next state HDR0.
  - Clears `done`, `err`, counters and checksum.
  - `core_rst_n` drops to 0 at the same edge.
- `boot_req` in any other state is ignored.
- Bytes presented while `in_ready=0` are not consumed.
- Counters are wide enough that address 2^ADDR_WIDTH-1 is written without overflow; N = 2^ADDR_WIDTH is legal.

## Timing
- All outputs are registered.
- Reset values:
  - `in_ready=0`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `core_rst_n=0`, `done=0`, `err=0`.
  - `in_ready` rises in the first cycle after reset release.
- `in_ready` = 1 exactly in HDR0, HDR1, DATA and CHK; one byte per cycle at full rate.
- Write timing: `imem_we` pulses for exactly one cycle, starting the cycle after the 4th byte of a word is accepted, with `imem_addr`/`imem_wdata` stable during that cycle.
- Back-to-back words give `imem_we` pulses 4 cycles apart.
- DONE: `core_rst_n` and `done` rise one cycle after the last write pulse (or the checksum byte). The core's first fetch therefore sees all writes complete.
- Reset assertion mid-load: immediate return to reset values. Partially written memory is not cleared; the next load overwrites it.

## Configuration
- `IMEM_BOOT_CHECKSUM_EN` defined:
  - CHK state present; trailing XOR byte required.
  - Mismatch → ERR, and the core stays in reset.
- Not defined: no CHK state; DATA and the N == 0 case go directly to DONE. The stream is exactly 2+4·N bytes.

## Structure
- Shared package `riscv_boot_pkg`:
  - State enum encoding.
  - Header length constant (2) and bytes-per-word constant (4).
- Single module; no sub-module. The word assembler is a few lines inside the FSM and does not warrant splitting.

## Test plan
- Stream 02 00, 13 00 10 00, 93 00 20 00 → writes 0x00100013 @0 and 0x00200093 @1, one `imem_we` cycle each; `core_rst_n`=1 one cycle after the second write.
- Header 00 00 → no `imem_we`; `done`=1 two cycles after the second header byte (no checksum build).
- ADDR_WIDTH=2, header 05 00 → `err`=1, `in_ready`=0, `core_rst_n` stays 0.
- Gaps in `in_valid` between every byte → same memory contents and address order as the full-rate case.
- Checksum build, 1 word DE AD BE EF:
  - Checksum 0x22 → `done`.
  - Checksum 0x23 → `err`.
  - Then `boot_req` plus a valid image → `done`.
- `RST` asserted after 3 of 4 bytes of word 0 → outputs at reset values.
- Fresh 1-word load afterwards writes correct data @0.
